// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the memory-stage load/store unit.
//   - funct3 encodings for the RV32I load/store sizes
//   - fault codes reported on FaultM
//   - FSM state encoding (also driven out on the debug state port)
package lsu_pkg;

    // Access size / sign encodings (funct3 of LB/LH/LW/LBU/LHU and SB/SH/SW)
    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Fault codes
    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUSY = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational helpers for the load/store unit.
//   Request side (current M-stage access):
//     memRead, memWrite  in   access type
//     funct3             in   size/sign
//     addr               in   byte address
//     writeData          in   rs2 store data
//     checkFault         out  FAULT_NONE / FAULT_MISALIGN / FAULT_ILLEGAL
//     byteEn             out  byte enables (1111 for loads)
//     laneData           out  store data replicated into the addressed lanes
//   Response side (latched access):
//     loadFunct3         in   funct3 captured at issue
//     loadOffset         in   byte offset captured at issue
//     rawData            in   raw memory word
//     loadData           out  selected and extended load value
module lsu_align
    import lsu_pkg::*;
(
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] writeData,
    output logic [1:0]  checkFault,
    output logic [3:0]  byteEn,
    output logic [31:0] laneData,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadOffset,
    input  logic [31:0] rawData,
    output logic [31:0] loadData
);

    logic        illegal;
    logic        misaligned;
    logic [31:0] shifted;

    // Legality and alignment. Illegal takes priority over misaligned because
    // an illegal funct3 has no meaningful alignment rule.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (memRead && memWrite) begin
            illegal = 1'b1;
        end else if (memRead) begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (memWrite) begin
            illegal = !((funct3 == LS_B) || (funct3 == LS_H) || (funct3 == LS_W));
        end

        case (funct3)
            LS_H, LS_HU: misaligned = addr[0];
            LS_W:        misaligned = (addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase

        checkFault = FAULT_NONE;
        if (memRead || memWrite) begin
            if (illegal) begin
                checkFault = FAULT_ILLEGAL;
            end else if (misaligned) begin
                checkFault = FAULT_MISALIGN;
            end
        end
    end

    // Store lane steering. Data is replicated across the word so the byte
    // enables alone select which lanes memory actually writes.
    always_comb begin
        byteEn   = 4'b1111;
        laneData = 32'h0;
        if (memWrite) begin
            case (funct3)
                LS_B: begin
                    byteEn   = 4'b0001 << addr[1:0];
                    laneData = {4{writeData[7:0]}};
                end
                LS_H: begin
                    byteEn   = addr[1] ? 4'b1100 : 4'b0011;
                    laneData = {2{writeData[15:0]}};
                end
                default: begin
                    byteEn   = 4'b1111;
                    laneData = writeData;
                end
            endcase
        end
    end

    // Load extraction: shift the addressed byte/halfword down to bit 0,
    // then extend according to the latched funct3.
    assign shifted = rawData >> {loadOffset, 3'b000};

    always_comb begin
        case (loadFunct3)
            LS_B:    loadData = {{24{shifted[7]}}, shifted[7:0]};
            LS_H:    loadData = {{16{shifted[15]}}, shifted[15:0]};
            LS_BU:   loadData = {24'h0, shifted[7:0]};
            LS_HU:   loadData = {16'h0, shifted[15:0]};
            default: loadData = rawData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: M-stage load/store unit between the pipelined datapath and
// data memory.
//
// Ports:
//   clk, reset       pipeline clock, synchronous active-high reset
//   MemReadM         M-stage load request
//   MemWriteM        M-stage store request
//   Funct3M          access size/sign
//   AddrM            byte address
//   WriteDataM       store data (rs2)
//   LoadDataM        extended load data (registered)
//   StallLSU         holds F..M stages while an access is in flight (combinational)
//   FaultM           00 none, 01 misaligned, 10 bus timeout, 11 illegal
//   mem_req/we/addr/wdata/be   registered memory request
//   mem_ready        memory completes the access this cycle
//   mem_rdata        raw read word, valid with mem_ready
//   lsuState         FSM state, for debug/observation
//
// Memory handshake: mem_req is the request valid and mem_ready is the
// completion. mem_req rises on the edge leaving IDLE and stays high, with
// mem_we/addr/wdata/be stable, until the first cycle mem_ready is sampled
// high while BUSY (the access completes on that edge) or the timeout expires.
// mem_ready in any other state is ignored.
//
// TIMEOUT (2..255) is the number of BUSY cycles waited for mem_ready.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] LoadDataM,
    output logic        StallLSU,
    output logic [1:0]  FaultM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output lsu_state_t  lsuState
);

    lsu_state_t  state;
    lsu_state_t  nextState;

    logic [1:0]  checkFault;
    logic [3:0]  byteEn;
    logic [31:0] laneData;
    logic [31:0] loadData;

    logic [1:0]  offsetQ;
    logic [2:0]  funct3Q;
    logic [7:0]  countQ;
    logic [1:0]  faultQ;

    logic        reqValid;
    logic        accept;
    logic        timeoutHit;

    lsu_align u_align (
        .memRead    (MemReadM),
        .memWrite   (MemWriteM),
        .funct3     (Funct3M),
        .addr       (AddrM),
        .writeData  (WriteDataM),
        .checkFault (checkFault),
        .byteEn     (byteEn),
        .laneData   (laneData),
        .loadFunct3 (funct3Q),
        .loadOffset (offsetQ),
        .rawData    (mem_rdata),
        .loadData   (loadData)
    );

    assign reqValid   = MemReadM || MemWriteM;
    assign accept     = (state == LSU_IDLE) && reqValid && (checkFault == FAULT_NONE);
    assign timeoutHit = (countQ == 8'(TIMEOUT - 1));
    assign lsuState   = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LSU_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, stall and fault output. Misaligned/illegal faults are
    // reported straight from the IDLE check; the timeout fault is the
    // recorded code shown during DONE.
    always_comb begin
        nextState = state;
        StallLSU  = 1'b0;
        FaultM    = FAULT_NONE;
        case (state)
            LSU_IDLE: begin
                FaultM = checkFault;
                if (accept) begin
                    StallLSU  = 1'b1;
                    nextState = LSU_BUSY;
                end
            end
            LSU_BUSY: begin
                StallLSU = 1'b1;
                if (mem_ready || timeoutHit) begin
                    nextState = LSU_DONE;
                end
            end
            LSU_DONE: begin
                // The instruction advances this cycle; its request is still
                // visible but must not be issued again.
                FaultM    = faultQ;
                nextState = LSU_IDLE;
            end
            default: nextState = LSU_IDLE;
        endcase
    end

    // Request latches, timeout counter and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            offsetQ   <= 2'b00;
            funct3Q   <= 3'b000;
            countQ    <= 8'h0;
            faultQ    <= FAULT_NONE;
            LoadDataM <= 32'h0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {AddrM[31:2], 2'b00};
                        mem_wdata <= laneData;
                        mem_be    <= byteEn;
                        offsetQ   <= AddrM[1:0];
                        funct3Q   <= Funct3M;
                        countQ    <= 8'h0;
                        faultQ    <= FAULT_NONE;
                    end
                end
                LSU_BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            LoadDataM <= loadData;
                        end
                    end else if (timeoutHit) begin
                        mem_req   <= 1'b0;
                        LoadDataM <= 32'h0;
                        faultQ    <= FAULT_TIMEOUT;
                    end else begin
                        countQ <= countQ + 8'h1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed test of load_store_unit with TIMEOUT=4.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] AddrM;
    logic [31:0] WriteDataM;
    logic [31:0] LoadDataM;
    logic        StallLSU;
    logic [1:0]  FaultM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    lsu_state_t  lsuState;

    int nChecks = 0;
    int nFail   = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .LoadDataM  (LoadDataM),
        .StallLSU   (StallLSU),
        .FaultM     (FaultM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .lsuState   (lsuState)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One legal access completing after 'waits' wait cycles in BUSY.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int waits,
                          input logic [3:0] expBe, input logic [31:0] expWdata,
                          input logic [31:0] expLoad, input string tag);
        logic [31:0] expAddr;
        expAddr    = {addr[31:2], 2'b00};
        MemReadM   = rd;
        MemWriteM  = wr;
        Funct3M    = f3;
        AddrM      = addr;
        WriteDataM = wd;
        #1;
        check({tag, " stall_issue"}, 32'(StallLSU), 32'd1);
        check({tag, " fault_issue"}, 32'(FaultM), 32'(FAULT_NONE));
        step();
        check({tag, " mem_req"}, 32'(mem_req), 32'd1);
        check({tag, " mem_we"}, 32'(mem_we), 32'(wr));
        check({tag, " mem_addr"}, mem_addr, expAddr);
        check({tag, " mem_be"}, 32'(mem_be), 32'(expBe));
        if (wr) check({tag, " mem_wdata"}, mem_wdata, expWdata);
        for (int i = 0; i < waits; i++) begin
            check({tag, " stall_wait"}, 32'(StallLSU), 32'd1);
            step();
            check({tag, " mem_req_wait"}, 32'(mem_req), 32'd1);
        end
        check({tag, " stall_busy"}, 32'(StallLSU), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check({tag, " state_done"}, 32'(lsuState), 32'(LSU_DONE));
        check({tag, " stall_done"}, 32'(StallLSU), 32'd0);
        check({tag, " mem_req_done"}, 32'(mem_req), 32'd0);
        check({tag, " fault_done"}, 32'(FaultM), 32'(FAULT_NONE));
        if (rd) check({tag, " load_data"}, LoadDataM, expLoad);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        step();
        check({tag, " state_idle"}, 32'(lsuState), 32'(LSU_IDLE));
        check({tag, " mem_req_idle"}, 32'(mem_req), 32'd0);
    endtask

    // Request rejected in IDLE with a combinational fault code.
    task automatic rejected(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [1:0] expFault,
                            input string tag);
        MemReadM  = rd;
        MemWriteM = wr;
        Funct3M   = f3;
        AddrM     = addr;
        #1;
        check({tag, " fault"}, 32'(FaultM), 32'(expFault));
        check({tag, " stall"}, 32'(StallLSU), 32'd0);
        step();
        check({tag, " state"}, 32'(lsuState), 32'(LSU_IDLE));
        check({tag, " mem_req"}, 32'(mem_req), 32'd0);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        #1;
        check({tag, " fault_clear"}, 32'(FaultM), 32'(FAULT_NONE));
    endtask

    initial begin
        reset      = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        AddrM      = 32'h0;
        WriteDataM = 32'h0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;
        step();
        step();

        // Reset values
        check("rst LoadDataM", LoadDataM, 32'h0);
        check("rst StallLSU", 32'(StallLSU), 32'd0);
        check("rst FaultM", 32'(FaultM), 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst mem_wdata", mem_wdata, 32'h0);
        check("rst mem_be", 32'(mem_be), 32'd0);
        check("rst state", 32'(lsuState), 32'(LSU_IDLE));
        reset = 1'b0;
        step();

        // mem_ready while IDLE is ignored
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        step();
        mem_ready = 1'b0;
        check("idle_ready state", 32'(lsuState), 32'(LSU_IDLE));
        check("idle_ready mem_req", 32'(mem_req), 32'd0);
        check("idle_ready LoadDataM", LoadDataM, 32'h0);

        // Loads
        access(1, 0, LS_W,  32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, "LW");
        access(1, 0, LS_B,  32'h0000_2003, 32'h0, 32'h80FF_1234, 0, 4'b1111, 32'h0, 32'hFFFF_FF80, "LB");
        access(1, 0, LS_BU, 32'h0000_2003, 32'h0, 32'h80FF_1234, 1, 4'b1111, 32'h0, 32'h0000_0080, "LBU");
        access(1, 0, LS_H,  32'h0000_2002, 32'h0, 32'h80FF_1234, 2, 4'b1111, 32'h0, 32'hFFFF_80FF, "LH");

        // Stores
        access(0, 1, LS_B, 32'h0000_3002, 32'h0000_00AB, 32'h0, 0, 4'b0100, 32'hABAB_ABAB, 32'h0, "SB");
        access(0, 1, LS_H, 32'h0000_3002, 32'h0000_1234, 32'h0, 1, 4'b1100, 32'h1234_1234, 32'h0, "SH");
        access(0, 1, LS_W, 32'h0000_3008, 32'hCAFE_F00D, 32'h0, 0, 4'b1111, 32'hCAFE_F00D, 32'h0, "SW");

        // Misaligned and illegal requests
        rejected(1, 0, LS_W,   32'h0000_1002, FAULT_MISALIGN, "LW_mis");
        rejected(0, 1, LS_H,   32'h0000_3001, FAULT_MISALIGN, "SH_mis");
        rejected(1, 0, 3'b011, 32'h0000_1000, FAULT_ILLEGAL,  "LD_f3");
        rejected(0, 1, LS_BU,  32'h0000_1000, FAULT_ILLEGAL,  "SBU_f3");
        rejected(1, 1, LS_W,   32'h0000_1000, FAULT_ILLEGAL,  "RW_both");

        // Timeout: mem_req high for exactly 4 cycles, then fault 10 in DONE
        MemReadM = 1'b1;
        Funct3M  = LS_W;
        AddrM    = 32'h0000_4000;
        #1;
        check("to stall_issue", 32'(StallLSU), 32'd1);
        step();
        for (int i = 0; i < 4; i++) begin
            check("to mem_req", 32'(mem_req), 32'd1);
            step();
        end
        check("to mem_req_drop", 32'(mem_req), 32'd0);
        check("to state_done", 32'(lsuState), 32'(LSU_DONE));
        check("to FaultM", 32'(FaultM), 32'(FAULT_TIMEOUT));
        check("to LoadDataM", LoadDataM, 32'h0);
        check("to stall_done", 32'(StallLSU), 32'd0);
        MemReadM = 1'b0;
        step();
        check("to state_idle", 32'(lsuState), 32'(LSU_IDLE));
        check("to fault_clear", 32'(FaultM), 32'(FAULT_NONE));

        access(1, 0, LS_HU, 32'h0000_2000, 32'h0, 32'h80FF_1234, 0, 4'b1111, 32'h0, 32'h0000_1234, "LHU");

        // Reset during BUSY after 3 wait cycles, then a late mem_ready
        MemReadM = 1'b1;
        Funct3M  = LS_W;
        AddrM    = 32'h0000_5000;
        step();
        step();
        step();
        step();
        check("rb mem_req_before", 32'(mem_req), 32'd1);
        check("rb state_before", 32'(lsuState), 32'(LSU_BUSY));
        reset    = 1'b1;
        MemReadM = 1'b0;
        step();
        check("rb state", 32'(lsuState), 32'(LSU_IDLE));
        check("rb LoadDataM", LoadDataM, 32'h0);
        check("rb StallLSU", 32'(StallLSU), 32'd0);
        check("rb FaultM", 32'(FaultM), 32'd0);
        check("rb mem_req", 32'(mem_req), 32'd0);
        check("rb mem_addr", mem_addr, 32'h0);
        check("rb mem_be", 32'(mem_be), 32'd0);
        reset     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("rb late_ready state", 32'(lsuState), 32'(LSU_IDLE));
        check("rb late_ready mem_req", 32'(mem_req), 32'd0);
        check("rb late_ready LoadDataM", LoadDataM, 32'h0);

        access(1, 0, LS_W, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 0, 4'b1111, 32'h0, 32'h0BAD_F00D, "LW_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
